// File: rtl/mips_multicycle_core.sv
// mips_multicycle_core
//   Multicycle MIPS-I subset core (add/sub/and/or/slt, lw, sw, beq, addi, j).
//   One FSM sequences a shared datapath; a single unified memory port serves
//   instruction fetch and data access with a req/ready handshake.
// Ports
//   CLOCK, RESET        rising-edge clock, synchronous active-high reset
//   mem_req/mem_we      access request and direction (1 = write)
//   mem_addr/mem_wdata  byte address and store data, held while stalled
//   mem_rdata/mem_ready read data and completion (req & ready completes)
//   retire              one-cycle pulse in the last state of each instruction
//   pc_out              architectural PC
//   halted              high while the core sits in HALT
module mips_multicycle_core #(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int          NUM_REGS        = 32,
  parameter bit          HALT_ON_ILLEGAL = 1'b1
) (
  input  logic        CLOCK,
  input  logic        RESET,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        retire,
  output logic [31:0] pc_out,
  output logic        halted
);

  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;

  localparam logic [5:0] F_ADD = 6'h20;
  localparam logic [5:0] F_SUB = 6'h22;
  localparam logic [5:0] F_AND = 6'h24;
  localparam logic [5:0] F_OR  = 6'h25;
  localparam logic [5:0] F_SLT = 6'h2A;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXEC,
    S_ALUWB, S_BRANCH, S_ADDIEX, S_ADDIWB, S_JUMP, S_HALT
  } state_t;

  state_t state, state_nxt;

  logic        [31:0] pc, ir, target, alu_out, mdr;
  logic signed [31:0] reg_a, reg_b;
  logic        [31:0] rf [NUM_REGS];

  logic [5:0]       opcode, funct;
  logic [IDX_W-1:0] rs_idx, rt_idx, rd_idx;
  logic signed [31:0] imm_sext;
  logic [31:0]      rs_val, rt_val;

  logic             rf_we, retire_c;
  logic [IDX_W-1:0] rf_waddr;
  logic [31:0]      rf_wdata;
  logic             unused_shamt;

  assign opcode       = ir[31:26];
  assign funct        = ir[5:0];
  assign rs_idx       = ir[21 +: IDX_W];
  assign rt_idx       = ir[16 +: IDX_W];
  assign rd_idx       = ir[11 +: IDX_W];
  assign imm_sext     = {{16{ir[15]}}, ir[15:0]};
  assign unused_shamt = ^ir[10:6];

  // $0 is hard-wired to zero on the read side as well as never written.
  assign rs_val = (rs_idx == '0) ? 32'd0 : rf[rs_idx];
  assign rt_val = (rt_idx == '0) ? 32'd0 : rf[rt_idx];

  function automatic logic rtype_legal(input logic [5:0] fn);
    return (fn == F_ADD) || (fn == F_SUB) || (fn == F_AND) ||
           (fn == F_OR)  || (fn == F_SLT);
  endfunction

  function automatic logic [31:0] alu_rtype(input logic [5:0] fn,
                                            input logic signed [31:0] x,
                                            input logic signed [31:0] y);
    case (fn)
      F_ADD:   return x + y;
      F_SUB:   return x - y;
      F_AND:   return x & y;
      F_OR:    return x | y;
      F_SLT:   return (x < y) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  always_comb begin
    state_nxt = state;
    retire_c  = 1'b0;
    rf_we     = 1'b0;
    rf_waddr  = '0;
    rf_wdata  = 32'd0;
    case (state)
      S_FETCH:  if (mem_ready) state_nxt = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_R:          state_nxt = rtype_legal(funct) ? S_EXEC : S_HALT;
          OP_LW, OP_SW:  state_nxt = S_MEMADR;
          OP_BEQ:        state_nxt = S_BRANCH;
          OP_ADDI:       state_nxt = S_ADDIEX;
          OP_J:          state_nxt = S_JUMP;
          default:       state_nxt = S_HALT;
        endcase
        // Illegal encodings retire here as a NOP when halting is disabled.
        if (state_nxt == S_HALT && !HALT_ON_ILLEGAL) begin
          state_nxt = S_FETCH;
          retire_c  = 1'b1;
        end
      end
      S_MEMADR: state_nxt = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (mem_ready) state_nxt = S_MEMWB;
      S_MEMWB: begin
        rf_we = 1'b1; rf_waddr = rt_idx; rf_wdata = mdr;
        retire_c = 1'b1; state_nxt = S_FETCH;
      end
      S_MEMWR: if (mem_ready) begin
        retire_c = 1'b1; state_nxt = S_FETCH;
      end
      S_EXEC:   state_nxt = S_ALUWB;
      S_ALUWB: begin
        rf_we = 1'b1; rf_waddr = rd_idx; rf_wdata = alu_out;
        retire_c = 1'b1; state_nxt = S_FETCH;
      end
      S_BRANCH: begin retire_c = 1'b1; state_nxt = S_FETCH; end
      S_ADDIEX: state_nxt = S_ADDIWB;
      S_ADDIWB: begin
        rf_we = 1'b1; rf_waddr = rt_idx; rf_wdata = alu_out;
        retire_c = 1'b1; state_nxt = S_FETCH;
      end
      S_JUMP:   begin retire_c = 1'b1; state_nxt = S_FETCH; end
      S_HALT:   state_nxt = S_HALT;
      default:  state_nxt = S_FETCH;
    endcase
  end

  // Control state: FSM, PC, IR and register file.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state <= S_FETCH;
      pc    <= RESET_PC;
      ir    <= 32'd0;
      for (int i = 0; i < NUM_REGS; i++) rf[i] <= 32'd0;
    end else begin
      state <= state_nxt;
      if (state == S_FETCH && mem_ready) begin
        ir <= mem_rdata;
        pc <= pc + 32'd4;
      end
      if (state == S_BRANCH && reg_a == reg_b) pc <= target;
      if (state == S_JUMP) pc <= {pc[31:28], ir[25:0], 2'b00};
      if (rf_we && rf_waddr != '0) rf[rf_waddr] <= rf_wdata;
    end
  end

  // Datapath registers; pc already holds PC+4 when DECODE computes the target.
  always_ff @(posedge CLOCK) begin
    case (state)
      S_DECODE: begin
        reg_a  <= rs_val;
        reg_b  <= rt_val;
        target <= pc + (imm_sext <<< 2);
      end
      S_MEMADR, S_ADDIEX: alu_out <= reg_a + imm_sext;
      S_EXEC:             alu_out <= alu_rtype(funct, reg_a, reg_b);
      S_MEMRD:            if (mem_ready) mdr <= mem_rdata;
      default: ;
    endcase
  end

  // State and registers are frozen while stalled, so the request stays stable.
  assign mem_req   = !RESET && (state == S_FETCH || state == S_MEMRD || state == S_MEMWR);
  assign mem_we    = !RESET && (state == S_MEMWR);
  assign mem_addr  = (state == S_MEMRD || state == S_MEMWR) ? alu_out : pc;
  assign mem_wdata = reg_b;
  assign retire    = !RESET && retire_c;
  assign halted    = !RESET && (state == S_HALT);
  assign pc_out    = pc;

endmodule

// File: tb/tb_mips_multicycle_core.sv
// tb_mips_multicycle_core
//   Directed bench for mips_multicycle_core (RESET_PC = 0x100). A unified
//   memory model overlays written words over the program image and can insert
//   wait states on selected read addresses.
module tb_mips_multicycle_core;

  localparam logic [31:0] RPC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr = 1'b1;
  logic        mem_req, mem_we, mem_ready, retire, halted;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, pc_out;

  logic [31:0] imem [256];
  logic [31:0] dmem [256];
  logic        dvalid [256];

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          ret_q[$];
  logic [31:0] rd_q[$];
  logic [31:0] wa_q[$];
  logic [31:0] wd_q[$];

  logic [31:0] stall_addr0 = 32'hFFFF_FFFF;
  logic [31:0] stall_addr1 = 32'hFFFF_FFFF;
  int          stall_lim0 = 0, stall_lim1 = 0;
  int          stall_used0 = 0, stall_used1 = 0;
  logic        stall0, stall1;

  mips_multicycle_core #(.RESET_PC(RPC), .NUM_REGS(32), .HALT_ON_ILLEGAL(1'b1)) dut (
    .CLOCK(clk), .RESET(rst), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .retire(retire), .pc_out(pc_out), .halted(halted)
  );

  always #5 clk = ~clk;

  assign stall0    = mem_req && !mem_we && mem_addr == stall_addr0 && stall_used0 < stall_lim0;
  assign stall1    = mem_req && !mem_we && mem_addr == stall_addr1 && stall_used1 < stall_lim1;
  assign mem_ready = mem_req && !stall0 && !stall1;
  assign mem_rdata = dvalid[mem_addr[9:2]] ? dmem[mem_addr[9:2]] : imem[mem_addr[9:2]];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (stall0) stall_used0 <= stall_used0 + 1;
    if (stall1) stall_used1 <= stall_used1 + 1;
    if (clr) begin
      for (int i = 0; i < 256; i++) begin
        dmem[i]   <= 32'd0;
        dvalid[i] <= 1'b0;
      end
      ret_q.delete(); rd_q.delete(); wa_q.delete(); wd_q.delete();
    end else begin
      if (retire) ret_q.push_back(cyc);
      if (mem_req && mem_ready) begin
        if (mem_we) begin
          dmem[mem_addr[9:2]]   <= mem_wdata;
          dvalid[mem_addr[9:2]] <= 1'b1;
          wa_q.push_back(mem_addr);
          wd_q.push_back(mem_wdata);
        end else begin
          rd_q.push_back(mem_addr);
        end
      end
    end
  end

  function automatic logic [31:0] f_r(input logic [4:0] rd, input logic [4:0] rs,
                                      input logic [4:0] rt, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction
  function automatic logic [31:0] f_i(input logic [5:0] op, input logic [4:0] rt,
                                      input logic [4:0] rs, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction
  function automatic logic [31:0] f_j(input logic [31:0] tgt);
    return {6'h02, tgt[27:2]};
  endfunction
  function automatic logic [7:0] widx(input logic [31:0] a);
    return a[9:2];
  endfunction

  task automatic load_prog(input logic [31:0] base, input logic [31:0] words[$]);
    for (int i = 0; i < 256; i++) imem[i] = 32'd0;
    for (int i = 0; i < words.size(); i++) imem[widx(base + 32'(4 * i))] = words[i];
  endtask

  task automatic do_reset();
    rst = 1'b1; clr = 1'b1;
    @(negedge clk); @(negedge clk);
    rst = 1'b0; clr = 1'b0;
    #1;
  endtask

  task automatic wait_retires(input int n, input int budget, output bit ok);
    int k = 0;
    while (ret_q.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    ok = (ret_q.size() >= n);
  endtask

  task automatic test_reset();
    logic [31:0] p[$];
    p = '{f_i(6'h08, 5'd1, 5'd0, 16'd5)};
    load_prog(RPC, p);
    rst = 1'b1; clr = 1'b1;
    @(negedge clk); @(negedge clk);
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rst_req got %b want 0", mem_req); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rst_we got %b want 0", mem_we); end
    checks++; if (retire !== 1'b0) begin errors++; $display("FAIL rst_retire got %b want 0", retire); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL rst_halted got %b want 0", halted); end
    rst = 1'b0; clr = 1'b0; #1;
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL first_req got %b want 1", mem_req); end
    checks++; if (mem_addr !== RPC) begin errors++; $display("FAIL first_addr got %h want %h", mem_addr, RPC); end
    checks++; if (pc_out !== RPC) begin errors++; $display("FAIL reset_pc got %h want %h", pc_out, RPC); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL post_rst_halted got %b want 0", halted); end
  endtask

  task automatic test_alu();
    logic [31:0] p[$];
    bit ok;
    p = '{f_i(6'h08, 5'd1, 5'd0, 16'd5),    f_i(6'h08, 5'd2, 5'd0, 16'hFFFD),
          f_r(5'd3, 5'd1, 5'd2, 6'h20),     f_r(5'd4, 5'd2, 5'd1, 6'h2A),
          f_r(5'd6, 5'd1, 5'd2, 6'h22),     f_r(5'd7, 5'd1, 5'd2, 6'h24),
          f_r(5'd8, 5'd1, 5'd2, 6'h25),     f_r(5'd9, 5'd1, 5'd2, 6'h2A),
          f_i(6'h2B, 5'd3, 5'd0, 16'h200),  f_i(6'h2B, 5'd4, 5'd0, 16'h204),
          f_i(6'h2B, 5'd6, 5'd0, 16'h208),  f_i(6'h2B, 5'd7, 5'd0, 16'h20C),
          f_i(6'h2B, 5'd8, 5'd0, 16'h210),  f_i(6'h2B, 5'd9, 5'd0, 16'h214)};
    load_prog(RPC, p);
    do_reset();
    wait_retires(14, 300, ok);
    checks++; if (!ok) begin errors++; $display("FAIL alu_timeout got %0d retires want 14", ret_q.size()); end
    checks++; if (ret_q[1] - ret_q[0] !== 4) begin errors++; $display("FAIL addi_gap got %0d want 4", ret_q[1] - ret_q[0]); end
    checks++; if (ret_q[2] - ret_q[1] !== 4) begin errors++; $display("FAIL add_gap got %0d want 4", ret_q[2] - ret_q[1]); end
    checks++; if (ret_q[3] - ret_q[2] !== 4) begin errors++; $display("FAIL slt_gap got %0d want 4", ret_q[3] - ret_q[2]); end
    checks++; if (ret_q[9] - ret_q[8] !== 4) begin errors++; $display("FAIL sw_gap got %0d want 4", ret_q[9] - ret_q[8]); end
    checks++; if (dmem[widx(32'h200)] !== 32'd2) begin errors++; $display("FAIL add got %h want 2", dmem[widx(32'h200)]); end
    checks++; if (dmem[widx(32'h204)] !== 32'd1) begin errors++; $display("FAIL slt_neg got %h want 1", dmem[widx(32'h204)]); end
    checks++; if (dmem[widx(32'h208)] !== 32'd8) begin errors++; $display("FAIL sub got %h want 8", dmem[widx(32'h208)]); end
    checks++; if (dmem[widx(32'h20C)] !== 32'd5) begin errors++; $display("FAIL and got %h want 5", dmem[widx(32'h20C)]); end
    checks++; if (dmem[widx(32'h210)] !== 32'hFFFF_FFFD) begin errors++; $display("FAIL or got %h want fffffffd", dmem[widx(32'h210)]); end
    checks++; if (dmem[widx(32'h214)] !== 32'd0) begin errors++; $display("FAIL slt_signed got %h want 0", dmem[widx(32'h214)]); end
  endtask

  task automatic test_load_store();
    logic [31:0] p[$];
    bit ok;
    p = '{f_i(6'h08, 5'd3, 5'd0, 16'd2),  f_i(6'h2B, 5'd3, 5'd0, 16'd8),
          f_i(6'h23, 5'd5, 5'd0, 16'd8),  f_i(6'h2B, 5'd5, 5'd0, 16'h220)};
    load_prog(RPC, p);
    do_reset();
    wait_retires(4, 100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL ls_timeout got %0d retires want 4", ret_q.size()); end
    checks++; if (wa_q[0] !== 32'd8) begin errors++; $display("FAIL sw_addr got %h want 8", wa_q[0]); end
    checks++; if (wd_q[0] !== 32'd2) begin errors++; $display("FAIL sw_data got %h want 2", wd_q[0]); end
    checks++; if (ret_q[2] - ret_q[1] !== 5) begin errors++; $display("FAIL lw_latency got %0d want 5", ret_q[2] - ret_q[1]); end
    checks++; if (dmem[widx(32'h220)] !== 32'd2) begin errors++; $display("FAIL lw_value got %h want 2", dmem[widx(32'h220)]); end
  endtask

  task automatic test_branch_jump();
    logic [31:0] p[$];
    logic [31:0] q[$];
    bit ok;
    int n104, n110;
    p = '{f_i(6'h08, 5'd1, 5'd0, 16'd3),      f_i(6'h08, 5'd1, 5'd1, 16'hFFFF),
          f_r(5'd2, 5'd1, 5'd0, 6'h2A),       f_i(6'h04, 5'd0, 5'd2, 16'hFFFD),
          f_j(32'h40)};
    load_prog(RPC, p);
    imem[widx(32'h40)] = f_i(6'h2B, 5'd1, 5'd0, 16'h230);
    do_reset();
    wait_retires(14, 300, ok);
    checks++; if (!ok) begin errors++; $display("FAIL br_timeout got %0d retires want 14", ret_q.size()); end
    checks++; if (pc_out !== 32'h40) begin errors++; $display("FAIL jump_pc got %h want 00000040", pc_out); end
    wait_retires(15, 50, ok);
    n104 = 0; n110 = 0;
    q = rd_q;
    foreach (q[i]) begin
      if (q[i] == 32'h104) n104++;
      if (q[i] == 32'h110) n110++;
    end
    checks++; if (n104 !== 4) begin errors++; $display("FAIL loop_fetches got %0d want 4", n104); end
    checks++; if (n110 !== 1) begin errors++; $display("FAIL exit_fetches got %0d want 1", n110); end
    checks++; if (ret_q[3] - ret_q[2] !== 3) begin errors++; $display("FAIL beq_latency got %0d want 3", ret_q[3] - ret_q[2]); end
    checks++; if (ret_q[13] - ret_q[12] !== 3) begin errors++; $display("FAIL j_latency got %0d want 3", ret_q[13] - ret_q[12]); end
    checks++; if (dmem[widx(32'h230)] !== 32'hFFFF_FFFF) begin errors++; $display("FAIL loop_count got %h want ffffffff", dmem[widx(32'h230)]); end
  endtask

  task automatic test_wait_states();
    logic [31:0] p[$];
    logic [31:0] prev_addr;
    logic        prev_we, prev_stall;
    int          viol, stalls, k;
    p = '{f_i(6'h08, 5'd1, 5'd0, 16'd7),      f_i(6'h2B, 5'd1, 5'd0, 16'h240),
          f_i(6'h23, 5'd5, 5'd0, 16'h240),    f_i(6'h2B, 5'd5, 5'd0, 16'h244)};
    load_prog(RPC, p);
    stall_addr0 = 32'h108; stall_lim0 = stall_used0 + 4;
    stall_addr1 = 32'h240; stall_lim1 = stall_used1 + 4;
    do_reset();
    viol = 0; stalls = 0; k = 0; prev_stall = 1'b0; prev_addr = 32'd0; prev_we = 1'b0;
    while (ret_q.size() < 4 && k < 200) begin
      if (prev_stall && (mem_req !== 1'b1 || mem_addr !== prev_addr || mem_we !== prev_we)) viol++;
      prev_stall = mem_req && !mem_ready;
      if (prev_stall) stalls++;
      prev_addr = mem_addr; prev_we = mem_we;
      @(negedge clk);
      k++;
    end
    checks++; if (ret_q.size() < 4) begin errors++; $display("FAIL ws_timeout got %0d retires want 4", ret_q.size()); end
    checks++; if (viol !== 0) begin errors++; $display("FAIL stall_stable got %0d changes want 0", viol); end
    checks++; if (stalls !== 8) begin errors++; $display("FAIL stall_cycles got %0d want 8", stalls); end
    checks++; if (ret_q[2] - ret_q[1] !== 13) begin errors++; $display("FAIL lw_wait_latency got %0d want 13", ret_q[2] - ret_q[1]); end
    checks++; if (dmem[widx(32'h244)] !== 32'd7) begin errors++; $display("FAIL ws_value got %h want 7", dmem[widx(32'h244)]); end
  endtask

  task automatic test_reset_mid_stall();
    logic [31:0] p[$];
    bit ok;
    p = '{f_i(6'h08, 5'd1, 5'd0, 16'd7), f_i(6'h23, 5'd5, 5'd0, 16'h240)};
    load_prog(RPC, p);
    stall_addr1 = 32'h240; stall_lim1 = stall_used1 + 20;
    do_reset();
    wait_retires(1, 50, ok);
    repeat (4) @(negedge clk);
    checks++; if (!(mem_req === 1'b1 && mem_addr === 32'h240)) begin errors++; $display("FAIL memrd_stall got req=%b addr=%h want 1/00000240", mem_req, mem_addr); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL midstall_req got %b want 0", mem_req); end
    checks++; if (pc_out !== RPC) begin errors++; $display("FAIL midstall_pc got %h want %h", pc_out, RPC); end
    stall_lim1 = stall_used1;
    rst = 1'b0; #1;
    checks++; if (mem_addr !== RPC || mem_req !== 1'b1) begin errors++; $display("FAIL restart got req=%b addr=%h want 1/%h", mem_req, mem_addr, RPC); end
  endtask

  task automatic test_halt();
    logic [31:0] p[$];
    bit ok;
    int reqs;
    p = '{f_i(6'h08, 5'd1, 5'd0, 16'd9),     f_i(6'h2B, 5'd1, 5'd0, 16'h250),
          f_i(6'h08, 5'd0, 5'd0, 16'd9),     f_i(6'h2B, 5'd0, 5'd0, 16'h250),
          32'hFC00_0000,                     f_i(6'h08, 5'd2, 5'd0, 16'd1),
          f_i(6'h2B, 5'd2, 5'd0, 16'h254)};
    load_prog(RPC, p);
    do_reset();
    wait_retires(4, 100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL halt_timeout got %0d retires want 4", ret_q.size()); end
    repeat (3) @(negedge clk);
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halted got %b want 1", halted); end
    reqs = 0;
    repeat (16) begin
      @(negedge clk);
      if (mem_req) reqs++;
    end
    checks++; if (reqs !== 0) begin errors++; $display("FAIL halt_reqs got %0d want 0", reqs); end
    checks++; if (ret_q.size() !== 4) begin errors++; $display("FAIL halt_retires got %0d want 4", ret_q.size()); end
    checks++; if (dmem[widx(32'h250)] !== 32'd0 || wd_q[0] !== 32'd9) begin errors++; $display("FAIL r0_write got %h (first %h) want 0 (first 9)", dmem[widx(32'h250)], wd_q[0]); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) imem[i] = 32'd0;
    test_reset();
    test_alu();
    test_load_store();
    test_branch_jump();
    test_wait_states();
    test_reset_mid_stall();
    test_halt();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
